// File: rtl/addr_decode_ws.sv
`default_nettype none
// ============================================================================
//  Module      : addr_decode_ws
//  Description : Address decoder with a wait-state generator. A request
//                address is matched against NREG programmable regions, and
//                the one-hot select is latched for the whole access. An
//                address that matches no region selects external memory.
//                The access is held for the wait-state count of the selected
//                target and ends with a one-cycle ready pulse.
//  Ports       : clk    - system clock, rising edge
//                rst    - asynchronous reset, active-high
//                req    - access request, sampled in IDLE only
//                we     - write flag, latched with the address
//                addr   - access address
//                cs     - one-hot internal region select
//                cs_ext - external memory select
//                we_q   - latched write flag
//                busy   - access in progress
//                ready  - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_decode_ws #(
    parameter int                     ADDR_W      = 32,
    parameter int                     NREG        = 2,
    parameter int                     DECODE_BITS = 16,
    parameter logic [NREG*ADDR_W-1:0] REG_FIRST   = '0,
    parameter logic [NREG*ADDR_W-1:0] REG_LAST    = '0,
    parameter logic [NREG*4-1:0]      REG_WS      = {NREG{4'd4}},
    parameter logic [3:0]             DEFAULT_WS  = 4'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   cs,
    output logic              cs_ext,
    output logic              we_q,
    output logic              busy,
    output logic              ready
);

    // Only the low DECODE_BITS take part in the compare.
    localparam logic [ADDR_W-1:0] c_mask = {ADDR_W{1'b1}} >> (ADDR_W - DECODE_BITS);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [3:0]        r_cnt;
    logic [NREG-1:0]   r_cs;
    logic              r_cs_ext;
    logic              r_we;
    logic              r_busy;

    logic [ADDR_W-1:0] w_addr_m;
    logic [NREG-1:0]   w_hit;
    logic [NREG-1:0]   w_sel;
    logic [3:0]        w_ws;

    assign w_addr_m = addr & c_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_region
            localparam logic [ADDR_W-1:0] c_first = REG_FIRST[gi*ADDR_W +: ADDR_W] & c_mask;
            localparam logic [ADDR_W-1:0] c_last  = REG_LAST[gi*ADDR_W +: ADDR_W] & c_mask;
            assign w_hit[gi] = (w_addr_m >= c_first) && (w_addr_m <= c_last);
        end
    endgenerate

    // Isolate the lowest set hit bit so overlapping regions resolve to the
    // lowest index.
    assign w_sel = w_hit & (~w_hit + NREG'(1));

    always_comb begin
        w_ws = DEFAULT_WS;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_ws = REG_WS[i*4 +: 4];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (req) begin
                    w_next = (w_ws == 4'd0) ? c_done : c_wait;
                end
            end
            c_wait: begin
                // <= guards against a stuck WAIT should cnt ever read zero.
                if (r_cnt <= 4'd1) begin
                    w_next = c_done;
                end
            end
            c_done:  w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_cnt    <= 4'd0;
            r_cs     <= '0;
            r_cs_ext <= 1'b0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_idle: begin
                    if (req) begin
                        r_cs     <= w_sel;
                        r_cs_ext <= ~|w_hit;
                        r_we     <= we;
                        r_busy   <= 1'b1;
                        r_cnt    <= w_ws;
                    end
                end
                c_wait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_done: begin
                    // we_q deliberately holds its value until the next accept.
                    r_cs     <= '0;
                    r_cs_ext <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_cs     <= '0;
                    r_cs_ext <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign cs     = r_cs;
    assign cs_ext = r_cs_ext;
    assign we_q   = r_we;
    assign busy   = r_busy;
    assign ready  = (r_state == c_done);

endmodule
`default_nettype wire

// File: tb/tb_addr_decode_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addr_decode_ws
//  Description : Self-checking bench for addr_decode_ws. Two instances run
//                side by side from the same stimulus: one decoding 16 address
//                bits, one decoding the full 32. Both are compared every cycle
//                against a transaction-level model of the access timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_decode_ws;

    localparam logic [63:0] c_first = {32'h0000_1000, 32'h0000_0A00};
    localparam logic [63:0] c_last  = {32'h0000_1FFF, 32'h0000_0DFF};
    localparam logic [7:0]  c_ws    = {4'd3, 4'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;

    logic [1:0] cs16, cs32;
    logic       ext16, ext32, weq16, weq32, busy16, busy32, rdy16, rdy32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addr_decode_ws #(
        .ADDR_W(32), .NREG(2), .DECODE_BITS(16),
        .REG_FIRST(c_first), .REG_LAST(c_last), .REG_WS(c_ws), .DEFAULT_WS(4'd5)
    ) dut16 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .cs(cs16), .cs_ext(ext16), .we_q(weq16), .busy(busy16), .ready(rdy16)
    );

    addr_decode_ws #(
        .ADDR_W(32), .NREG(2), .DECODE_BITS(32),
        .REG_FIRST(c_first), .REG_LAST(c_last), .REG_WS(c_ws), .DEFAULT_WS(4'd5)
    ) dut32 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .cs(cs32), .cs_ext(ext32), .we_q(weq32), .busy(busy32), .ready(rdy32)
    );

    // ---------------- reference model ----------------
    // One access = a target (region index or -1 for external) plus a count
    // of cycles still to go before the ready cycle.
    int          db_tab[2]    = '{16, 32};
    int unsigned first_tab[2] = '{32'h0A00, 32'h1000};
    int unsigned last_tab[2]  = '{32'h0DFF, 32'h1FFF};
    int          ws_tab[2]    = '{0, 3};
    int          ext_ws       = 5;

    bit m_busy[2];
    int m_left[2];
    int m_sel[2];
    bit m_we[2];

    function automatic int decode(input logic [31:0] a, input int db);
        logic [63:0] m;
        logic [31:0] am;
        m  = (64'd1 << db) - 64'd1;
        am = a & m[31:0];
        for (int i = 0; i < 2; i++) begin
            if ((am >= (first_tab[i] & m[31:0])) && (am <= (last_tab[i] & m[31:0])))
                return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_left[d] = 0;
            m_sel[d]  = -1;
            m_we[d]   = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (!m_busy[d]) begin
                if (req) begin
                    m_sel[d]  = decode(addr, db_tab[d]);
                    m_left[d] = (m_sel[d] < 0) ? ext_ws : ws_tab[m_sel[d]];
                    m_busy[d] = 1'b1;
                    m_we[d]   = we;
                end
            end else if (m_left[d] == 0) begin
                m_busy[d] = 1'b0;
            end else begin
                m_left[d] = m_left[d] - 1;
            end
        end
    endtask

    function automatic logic [5:0] expect_vec(input int d);
        logic [1:0] c;
        c = 2'b00;
        if (m_busy[d] && m_sel[d] >= 0) c[m_sel[d]] = 1'b1;
        return {c, m_busy[d] && (m_sel[d] < 0), m_we[d], m_busy[d],
                m_busy[d] && (m_left[d] == 0)};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("out16 {cs,ext,weq,busy,rdy}", {cs16, ext16, weq16, busy16, rdy16}, expect_vec(0));
        check("out32 {cs,ext,weq,busy,rdy}", {cs32, ext32, weq32, busy32, rdy32}, expect_vec(1));
        check("onehot16", 32'(($countones({cs16, ext16}) == (busy16 ? 1 : 0))), 1);
        check("onehot32", 32'(($countones({cs32, ext32}) == (busy32 ? 1 : 0))), 1);
        check("rdy_busy16", rdy16 & ~busy16, 0);
        check("rdy_busy32", rdy32 & ~busy32, 0);
    endtask

    // Drive at the negedge, clock, advance model, compare at the next negedge.
    task automatic step(input bit r, input logic [31:0] a, input bit w);
        req  = r;
        addr = a;
        we   = w;
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Single access on the 16-bit decoder: cycles from accept to ready and
    // number of busy cycles, against fixed expectations.
    task automatic measure(input logic [31:0] a, input bit w, input int exp_lat,
                           input int exp_busy, input string tag);
        int lat;
        int nb;
        lat = -1;
        nb  = 0;
        step(1'b1, a, w);
        for (int k = 1; k <= 20; k++) begin
            if (busy16) nb++;
            if (rdy16 && lat < 0) lat = k;
            if (!busy16) break;
            step(1'b0, 32'h0, 1'b0);
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, nb, exp_busy);
    endtask

    // Reset asserted between clock edges; outputs must drop without an edge.
    task automatic mid_reset(input int hold);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("async_clear", {cs16, ext16, weq16, busy16, rdy16}, 0);
        for (int k = 0; k < hold; k++) step(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_rdy;
        int sel;
        logic [31:0] a;
        logic [31:0] bnd[8];

        bnd = '{32'h09FF, 32'h0A00, 32'h0DFF, 32'h0E00,
                32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000};

        rst  = 1'b1;
        req  = 1'b0;
        we   = 1'b0;
        addr = 32'h0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // external below and above region 0
        measure(32'h0000_09FF, 1'b0, 6, 6, "ext_lo");
        measure(32'h0000_0E00, 1'b0, 6, 6, "ext_hi");
        // region 0 edges, zero wait states
        measure(32'h0000_0A00, 1'b0, 1, 1, "r0_lo");
        measure(32'h0000_0DFF, 1'b0, 1, 1, "r0_hi");
        // upper bits ignored at 16-bit decode; external at full decode
        measure(32'hFFFF_0B00, 1'b0, 1, 1, "r0_upper");
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b0);

        // region 1 write, second request during the access is dropped
        step(1'b1, 32'h0000_1000, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0A00, 1'b0);
        check("ignored_cs", cs16, 2'b10);
        check("ignored_weq", weq16, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b0);
        measure(32'h0000_1000, 1'b1, 4, 4, "r1");

        // reset mid-access, then a normal access
        step(1'b1, 32'h0000_1FFF, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        mid_reset(2);
        measure(32'h0000_1FFF, 1'b0, 4, 4, "after_rst");
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b0);

        // back-to-back with req held high: no two consecutive ready cycles
        prev_rdy = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 32'h0000_0C00, 1'b0);
            check("no_double_ready", prev_rdy & rdy16, 0);
            prev_rdy = rdy16;
        end
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b0);

        // random traffic with occasional asynchronous reset
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       a = $urandom;
                1:       a = 32'h0A00 + $urandom_range(0, 32'h3FF);
                2:       a = 32'h1000 + $urandom_range(0, 32'hFFF);
                3:       a = bnd[$urandom_range(0, 7)];
                default: a = {16'($urandom), bnd[$urandom_range(0, 7)][15:0]};
            endcase
            if ($urandom_range(0, 59) == 0) begin
                mid_reset(int'($urandom_range(1, 2)));
            end else begin
                step(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
